// File: rtl/alu_16bit.sv
// Registered 16-bit CR16-style integer ALU: result and condition flags are
// computed combinationally and captured together, one cycle of latency.
module alu_16bit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  Opcode,
  input  logic        carryIn,
  output logic [15:0] C,
  output logic [4:0]  Flags
);

  logic [15:0] c_q, c_d;
  logic [4:0]  flags_q, flags_d;

  logic [15:0] r;
  logic        cf, ff, lf, nf, zf;
  logic        known, is_cmp;
  logic        cin_use;
  logic [16:0] sum, diff;
  logic [15:0] neg_b;

  always_comb begin
    r       = '0;
    cf      = 1'b0;
    ff      = 1'b0;
    lf      = 1'b0;
    nf      = 1'b0;
    zf      = 1'b0;
    known   = 1'b1;
    is_cmp  = 1'b0;
    cin_use = 1'b0;
    neg_b   = 16'h0000 - B;

    // Only the carry variants pull carryIn into the adder.
    unique case (Opcode)
      8'h07, 8'h70, 8'h04, 8'h40: cin_use = carryIn;
      default:                    cin_use = 1'b0;
    endcase
    sum  = {1'b0, A} + {1'b0, B} + {16'h0000, cin_use};
    diff = {1'b0, A} - {1'b0, B};

    case (Opcode)
      8'h05, 8'h50, 8'h07, 8'h70: begin
        r  = sum[15:0];
        cf = sum[16];
        ff = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      8'h06, 8'h60, 8'h04, 8'h40: begin
        r  = sum[15:0];
        cf = sum[16];
      end
      8'h09, 8'h90: begin
        r  = diff[15:0];
        cf = diff[16];
        ff = (A[15] != B[15]) && (diff[15] != A[15]);
      end
      8'h0B, 8'hB0: begin
        r      = A;
        is_cmp = 1'b1;
      end
      8'h01, 8'h10: r = A & B;
      8'h02, 8'h20: r = A | B;
      8'h03, 8'h30: r = A ^ B;
      8'h0D, 8'hD0: r = B;
      // B is a signed count; negative counts shift right logically.
      8'h84, 8'h80: r = B[15] ? (A >> neg_b[3:0]) : (A << B[3:0]);
      8'hF0:        r = {B[7:0], 8'h00};
      default:      known = 1'b0;
    endcase

    if (is_cmp) begin
      zf = (A == B);
      lf = (A < B);
      nf = ($signed(A) < $signed(B));
    end else if (known) begin
      zf = (r == 16'h0000);
      nf = r[15];
    end
  end

  assign c_d     = r;
  assign flags_d = {zf, cf, ff, lf, nf};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      c_q     <= c_d;
      flags_q <= flags_d;
    end
  end

  assign C     = c_q;
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu_16bit.sv
// Directed-vector bench for alu_16bit; each scenario task checks its own results.
module tb_alu_16bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] A, B;
  logic [7:0]  Opcode;
  logic        carryIn;
  logic [15:0] C;
  logic [4:0]  Flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] c;
    logic [4:0]  f;
  } vec_t;

  alu_16bit dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B),
    .Opcode(Opcode), .carryIn(carryIn), .C(C), .Flags(Flags)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
    @(negedge clk);
    Opcode = op; A = a; B = b; carryIn = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(8'h05, 16'h0005, 16'h0003, 1'b0);
    step(8'h05, 16'h0005, 16'h0003, 1'b0);
    n_checks++;
    if ({C, Flags} !== {16'h0000, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_hold: C=%h Flags=%b, expected C=0000 Flags=00000", C, Flags);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({C, Flags} !== {16'h0008, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_release: C=%h Flags=%b, expected C=0008 Flags=00000", C, Flags);
    end
  endtask

  task automatic test_add();
    vec_t v[7] = '{
      '{8'h05, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 5'b00101},
      '{8'h06, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 5'b11000},
      '{8'h07, 16'h0001, 16'h0001, 1'b1, 16'h0003, 5'b00000},
      '{8'h40, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 5'b11000},
      '{8'h60, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 5'b00001},
      '{8'h70, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b00101},
      '{8'h50, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 5'b01001}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b, v[i].ci);
      n_checks++;
      if ({C, Flags} !== {v[i].c, v[i].f}) begin
        n_fail++;
        $display("FAIL add[%0d] op=%h: C=%h Flags=%b, expected C=%h Flags=%b",
                 i, v[i].op, C, Flags, v[i].c, v[i].f);
      end
    end
  endtask

  task automatic test_sub_cmp();
    vec_t v[6] = '{
      '{8'h09, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 5'b01001},
      '{8'h09, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 5'b00100},
      '{8'h90, 16'h0005, 16'h0005, 1'b0, 16'h0000, 5'b10000},
      '{8'h0B, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 5'b00001},
      '{8'hB0, 16'h1234, 16'h1234, 1'b0, 16'h1234, 5'b10000},
      '{8'h0B, 16'h0001, 16'hFFFF, 1'b1, 16'h0001, 5'b00010}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b, v[i].ci);
      n_checks++;
      if ({C, Flags} !== {v[i].c, v[i].f}) begin
        n_fail++;
        $display("FAIL sub_cmp[%0d] op=%h: C=%h Flags=%b, expected C=%h Flags=%b",
                 i, v[i].op, C, Flags, v[i].c, v[i].f);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v[10] = '{
      '{8'h01, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 5'b00000},
      '{8'h20, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFFF0, 5'b00001},
      '{8'h03, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 5'b10000},
      '{8'hD0, 16'h1234, 16'h8001, 1'b0, 16'h8001, 5'b00001},
      '{8'h84, 16'h00F0, 16'h0004, 1'b0, 16'h0F00, 5'b00000},
      '{8'h84, 16'h00F0, 16'hFFFC, 1'b0, 16'h000F, 5'b00000},
      '{8'h80, 16'h8001, 16'h000F, 1'b0, 16'h8000, 5'b00001},
      '{8'h80, 16'h8000, 16'hFFF1, 1'b0, 16'h0001, 5'b00000},
      '{8'hF0, 16'h5555, 16'h00AB, 1'b0, 16'hAB00, 5'b00001},
      '{8'hEE, 16'h0005, 16'h0003, 1'b1, 16'h0000, 5'b00000}
    };
    foreach (v[i]) begin
      step(v[i].op, v[i].a, v[i].b, v[i].ci);
      n_checks++;
      if ({C, Flags} !== {v[i].c, v[i].f}) begin
        n_fail++;
        $display("FAIL logic_shift[%0d] op=%h: C=%h Flags=%b, expected C=%h Flags=%b",
                 i, v[i].op, C, Flags, v[i].c, v[i].f);
      end
    end
  endtask

  task automatic test_hold_and_midreset();
    step(8'h05, 16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    Opcode = 8'h03; A = 16'hAAAA; B = 16'h5555;
    #3;
    n_checks++;
    if ({C, Flags} !== {16'h0003, 5'b00000}) begin
      n_fail++;
      $display("FAIL hold: C=%h Flags=%b, expected C=0003 Flags=00000", C, Flags);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({C, Flags} !== {16'hFFFF, 5'b00001}) begin
      n_fail++;
      $display("FAIL after_hold: C=%h Flags=%b, expected C=FFFF Flags=00001", C, Flags);
    end
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({C, Flags} !== {16'h0000, 5'b00000}) begin
      n_fail++;
      $display("FAIL mid_reset: C=%h Flags=%b, expected C=0000 Flags=00000", C, Flags);
    end
    @(negedge clk); reset_n = 1'b1;
    Opcode = 8'h0D; B = 16'h0042;
    @(posedge clk); #1;
    n_checks++;
    if ({C, Flags} !== {16'h0042, 5'b00000}) begin
      n_fail++;
      $display("FAIL post_reset: C=%h Flags=%b, expected C=0042 Flags=00000", C, Flags);
    end
  endtask

  initial begin
    reset_n = 1'b0; A = '0; B = '0; Opcode = '0; carryIn = 1'b0;
    test_reset();
    test_add();
    test_sub_cmp();
    test_logic_shift();
    test_hold_and_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
